// File: rtl/wave_window_pkg.sv
// Shared types for the waveform window generator: channel modes, FSM states,
// the default-width channel config record and the mode shaping helper.
package wave_window_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        LEVEL  = 2'd1,
        STROBE = 2'd2,
        INVERT = 2'd3
    } wave_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } wave_state_e;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] lo;
        logic [DEF_CNT_W-1:0] hi;
        wave_mode_e           mode;
    } ch_cfg_t;

    function automatic logic shape_wave(input wave_mode_e mode, input logic active,
                                        input logic phase);
        logic res;
        case (mode)
            LEVEL:   res = active;
            STROBE:  res = active & ~phase;
            INVERT:  res = ~active;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wave_window_ch.sv
// One output channel: config register, inclusive window compare and mode shaping.
// WAVE_WINDOW_MIRROR_EN adds a second window mirrored about the frame centre.
module wave_window_ch
    import wave_window_pkg::*;
#(
    parameter int CNT_W     = 16
`ifdef WAVE_WINDOW_MIRROR_EN
    ,
    parameter int FRAME_LEN = 1000
`endif
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_wr_en,
    input  logic [CNT_W-1:0] i_lo,
    input  logic [CNT_W-1:0] i_hi,
    input  logic [1:0]       i_mode,
    input  logic             i_run_n,
    input  logic             i_phase_n,
    input  logic [CNT_W-1:0] i_cnt_n,
    output logic             o_wave
);

    typedef struct packed {
        logic [CNT_W-1:0] lo;
        logic [CNT_W-1:0] hi;
        wave_mode_e       mode;
    } cfg_t;

`ifdef WAVE_WINDOW_MIRROR_EN
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
`endif

    cfg_t r_cfg;
    cfg_t w_cfg_n;
    logic w_active;
    logic w_wave_n;
    logic r_wave;

    // The wave is evaluated against the post-edge config so a write that
    // coincides with run start already shapes the first RUN cycle.
    always_comb begin
        w_cfg_n = r_cfg;
        if (i_wr_en) begin
            w_cfg_n.lo   = i_lo;
            w_cfg_n.hi   = i_hi;
            w_cfg_n.mode = wave_mode_e'(i_mode);
        end
        w_active = (w_cfg_n.lo <= i_cnt_n) && (i_cnt_n <= w_cfg_n.hi);
`ifdef WAVE_WINDOW_MIRROR_EN
        if ((w_cfg_n.hi <= LAST) && (w_cfg_n.lo <= w_cfg_n.hi) &&
            ((LAST - w_cfg_n.hi) <= i_cnt_n) && (i_cnt_n <= (LAST - w_cfg_n.lo))) begin
            w_active = 1'b1;
        end
`endif
        w_wave_n = i_run_n & shape_wave(w_cfg_n.mode, w_active, i_phase_n);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg  <= '{lo: '0, hi: '0, mode: OFF};
            r_wave <= 1'b0;
        end else begin
            r_cfg  <= w_cfg_n;
            r_wave <= w_wave_n;
        end
    end

    assign o_wave = r_wave;

endmodule

// File: rtl/wave_window_gen.sv
// Multi-channel waveform window generator: frame counter, run FSM and config port.
// Optional mirrored windows are enabled with WAVE_WINDOW_MIRROR_EN.
module wave_window_gen
    import wave_window_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int CNT_W     = 16,
    parameter int FRAME_LEN = 1000,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       num_frames,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_lo,
    input  logic [CNT_W-1:0] cfg_hi,
    input  logic [1:0]       cfg_mode,
    output logic [N_CH-1:0]  wave,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             frame_done,
    output logic             busy,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    wave_state_e      r_state, w_state_n;
    logic [CNT_W-1:0] r_cnt, w_cnt_n;
    logic [7:0]       r_left, w_left_n;
    logic             r_inf, w_inf_n;
    logic             r_phase, w_phase_n;
    logic             r_frame_done, r_busy, r_done, r_cfg_ready;
    logic             w_cfg_acc;
    logic             w_run_n;

    // Config handshake: a write transfers on any edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high exactly while IDLE.
    assign w_cfg_acc = cfg_valid && r_cfg_ready;
    assign w_run_n   = (w_state_n == RUN);

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_left_n  = r_left;
        w_inf_n   = r_inf;
        w_phase_n = r_phase;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_n = RUN;
                    w_cnt_n   = '0;
                    w_left_n  = num_frames;
                    w_inf_n   = (num_frames == 8'd0);
                    w_phase_n = 1'b0;
                end
            end
            RUN: begin
                if (stop) begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end else begin
                    w_phase_n = ~r_phase;
                    if (r_cnt == LAST) begin
                        w_cnt_n = '0;
                        if (!r_inf) begin
                            if (r_left == 8'd1) w_state_n = DONE;
                            else                w_left_n  = r_left - 8'd1;
                        end
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_left       <= '0;
            r_inf        <= 1'b0;
            r_phase      <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_ready  <= 1'b1;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_left       <= w_left_n;
            r_inf        <= w_inf_n;
            r_phase      <= w_phase_n;
            r_frame_done <= w_run_n && (w_cnt_n == LAST);
            r_busy       <= w_run_n;
            r_done       <= (w_state_n == DONE);
            r_cfg_ready  <= (w_state_n == IDLE);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        wave_window_ch #(
            .CNT_W     (CNT_W)
`ifdef WAVE_WINDOW_MIRROR_EN
            ,
            .FRAME_LEN (FRAME_LEN)
`endif
        ) u_ch (
            .clk       (clk),
            .reset_n   (reset_n),
            .i_wr_en   (w_cfg_acc && (cfg_ch == CH_W'(gi))),
            .i_lo      (cfg_lo),
            .i_hi      (cfg_hi),
            .i_mode    (cfg_mode),
            .i_run_n   (w_run_n),
            .i_phase_n (w_phase_n),
            .i_cnt_n   (w_cnt_n),
            .o_wave    (wave[gi])
        );
    end

    assign frame_cnt   = r_cnt;
    assign frame_done  = r_frame_done;
    assign busy        = r_busy;
    assign done        = r_done;
    assign cfg_ready   = r_cfg_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_wave_window_gen.sv
// Bench for wave_window_gen (3 channels, 20-cycle frames) with a cycle model
// feeding an expected-output queue, plus a window probe table.
module tb_wave_window_gen;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int FL  = 20;
    localparam int OW  = 25;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, stop;
    logic [7:0]    num_frames;
    logic          cfg_valid, cfg_ready;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_lo, cfg_hi;
    logic [1:0]    cfg_mode;
    logic [NCH-1:0] wave;
    logic [CW-1:0] frame_cnt;
    logic          frame_done, busy, done;
    logic [1:0]    dbg_state;

    localparam logic [OW-1:0] RESET_VEC = {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 3'd0};

    wave_window_gen #(.N_CH(NCH), .CNT_W(CW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .num_frames(num_frames), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode),
        .wave(wave), .frame_cnt(frame_cnt), .frame_done(frame_done),
        .busy(busy), .done(done), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // reference model state: 0 idle, 1 run, 2 done
    int m_state, m_cnt, m_left, m_rc;
    bit m_inf;
    int m_lo[NCH], m_hi[NCH], m_mode[NCH];

    logic [OW-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_done_pulses = 0;

    typedef struct {
        int ch; int lo; int hi; int mode; int probe; bit exp_bit;
    } probe_t;
    probe_t tbl[10];

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_left = 0; m_rc = 0; m_inf = 0;
        for (int i = 0; i < NCH; i++) begin
            m_lo[i] = 0; m_hi[i] = 0; m_mode[i] = 0;
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        logic [NCH-1:0] w;
        bit act;
        w = '0;
        for (int i = 0; i < NCH; i++) begin
            act = (m_lo[i] <= m_cnt) && (m_cnt <= m_hi[i]);
`ifdef WAVE_WINDOW_MIRROR_EN
            if (m_hi[i] <= FL - 1 && m_lo[i] <= m_hi[i] &&
                m_cnt >= FL - 1 - m_hi[i] && m_cnt <= FL - 1 - m_lo[i]) act = 1;
`endif
            if (m_state == 1) begin
                case (m_mode[i])
                    1: w[i] = act;
                    2: w[i] = act && (m_rc % 2 == 0);
                    3: w[i] = !act;
                    default: w[i] = 1'b0;
                endcase
            end
        end
        return {2'(m_state), m_state == 0, m_state == 1, m_state == 2,
                (m_state == 1) && (m_cnt == FL - 1), 16'(m_cnt), w};
    endfunction

    task automatic model_edge();
        if (cfg_valid && m_state == 0 && int'(cfg_ch) < NCH) begin
            m_lo[cfg_ch] = int'(cfg_lo);
            m_hi[cfg_ch] = int'(cfg_hi);
            m_mode[cfg_ch] = int'(cfg_mode);
        end
        case (m_state)
            0: if (start && !stop) begin
                m_state = 1; m_cnt = 0; m_rc = 0;
                m_left = int'(num_frames); m_inf = (num_frames == 0);
            end
            1: if (stop) begin
                m_state = 0; m_cnt = 0;
            end else begin
                m_rc++;
                if (m_cnt == FL - 1) begin
                    m_cnt = 0;
                    if (!m_inf) begin
                        if (m_left == 1) m_state = 2;
                        else m_left--;
                    end
                end else m_cnt++;
            end
            default: begin m_state = 0; m_cnt = 0; end
        endcase
    endtask

    task automatic check_out(input string name);
        logic [OW-1:0] a, e;
        a = {dbg_state, cfg_ready, busy, done, frame_done, frame_cnt, wave};
        n_checks++;
        if (done) n_done_pulses++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s at %0t: no expected entry, got %h", name, $time, a);
            return;
        end
        e = exp_q.pop_front();
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h (st,rdy,busy,done,fd,cnt,wave)",
                     name, $time, a, e);
        end
    endtask

    task automatic step();
        model_edge();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        check_out("cycle");
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    task automatic cfg_write(input int ch, input int lo, input int hi, input int mode);
        cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_lo = 16'(lo); cfg_hi = 16'(hi);
        cfg_mode = 2'(mode);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic start_run(input int nf);
        start = 1'b1; num_frames = 8'(nf);
        step();
        start = 1'b0;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bound;
        tbl[0] = '{0, 5, 8, 1, 5, 1'b1};
        tbl[1] = '{0, 5, 8, 1, 4, 1'b0};
        tbl[2] = '{0, 5, 8, 1, 8, 1'b1};
        tbl[3] = '{0, 5, 8, 1, 9, 1'b0};
        tbl[4] = '{1, 4, 9, 2, 6, 1'b1};
        tbl[5] = '{1, 4, 9, 2, 7, 1'b0};
        tbl[6] = '{2, 4, 9, 3, 4, 1'b0};
        tbl[7] = '{2, 4, 9, 3, 17, 1'b1};
        tbl[8] = '{0, 9, 4, 1, 6, 1'b0};
        tbl[9] = '{1, 15, 40, 1, 19, 1'b1};

        reset_n = 1'b0; start = 0; stop = 0; num_frames = 0;
        cfg_valid = 0; cfg_ch = 0; cfg_lo = 0; cfg_hi = 0; cfg_mode = 0;
        model_reset();
        #12;
        check_val("reset_outputs",
                  int'({dbg_state, cfg_ready, busy, done, frame_done, frame_cnt, wave}),
                  int'(RESET_VEC));
        reset_n = 1'b1;
        run_cycles(3);

        for (int k = 0; k < 10; k++) begin
            cfg_write(tbl[k].ch, tbl[k].lo, tbl[k].hi, tbl[k].mode);
            start_run(1);
            bound = 0;
            while (int'(frame_cnt) != tbl[k].probe && bound < 40) begin
                step();
                bound++;
            end
            n_checks++;
            if (int'(frame_cnt) != tbl[k].probe || wave[tbl[k].ch] !== tbl[k].exp_bit) begin
                n_fail++;
                $display("FAIL probe%0d: cnt=%0d wave[%0d]=%b expected cnt=%0d wave=%b",
                         k, frame_cnt, tbl[k].ch, wave[tbl[k].ch], tbl[k].probe, tbl[k].exp_bit);
            end
            stop = 1'b1; step(); stop = 1'b0;
        end

        // single-frame LEVEL run
        cfg_write(0, 5, 8, 1); cfg_write(1, 0, 0, 0); cfg_write(2, 0, 0, 0);
        n_done_pulses = 0;
        start_run(1);
        run_cycles(24);
        check_val("done_pulses_1frame", n_done_pulses, 1);

        // two-frame STROBE / INVERT run
        cfg_write(0, 0, 0, 0); cfg_write(1, 4, 9, 2); cfg_write(2, 4, 9, 3);
        n_done_pulses = 0;
        start_run(2);
        run_cycles(44);
        check_val("done_pulses_2frame", n_done_pulses, 1);

        // endless run stopped at frame 3 position 7, then start+stop together
        n_done_pulses = 0;
        start_run(0);
        run_cycles(47);
        check_val("stop_position", int'(frame_cnt), 7);
        stop = 1'b1; step(); stop = 1'b0;
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        run_cycles(2);
        check_val("no_done_after_stop", n_done_pulses, 0);

        // config writes during RUN ignored, out-of-range channel dropped, empty window
        start_run(1);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_lo = 16'd0; cfg_hi = 16'd19; cfg_mode = 2'd3;
        run_cycles(3);
        cfg_valid = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        cfg_write(3, 0, 19, 1);
        cfg_write(0, 9, 4, 1);
        start_run(1);
        run_cycles(21);

        // randomised configs and runs with sporadic start/stop pulses
        repeat (6) begin
            repeat (3) cfg_write($urandom_range(0, 3), $urandom_range(0, 24),
                                 $urandom_range(0, 24), $urandom_range(0, 3));
            start_run($urandom_range(0, 2));
            repeat ($urandom_range(10, 50)) begin
                stop  = ($urandom_range(0, 15) == 0);
                start = ($urandom_range(0, 7) == 0);
                num_frames = 8'($urandom_range(0, 2));
                step();
            end
            start = 1'b0;
            stop = 1'b1; step(); stop = 1'b0;
        end

        // asynchronous reset in the middle of a run
        cfg_write(0, 5, 8, 1); cfg_write(2, 4, 9, 3);
        start_run(0);
        run_cycles(12);
        #3 reset_n = 1'b0;
        #1;
        check_val("async_reset_outputs",
                  int'({dbg_state, cfg_ready, busy, done, frame_done, frame_cnt, wave}),
                  int'(RESET_VEC));
        model_reset();
        #22 reset_n = 1'b1;
        run_cycles(5);
        start_run(1);
        run_cycles(22);

        check_val("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wave_window_gen.md
Name: wave_window_gen

Overview:
- Multi-channel, parametrised waveform window generator for drawing banner/flag patterns in waveform viewers and for directed timing stimulus.
- A free-running frame counter sweeps 0..FRAME_LEN-1. Each channel asserts its output inside a programmable inclusive window [lo,hi], shaped by a per-channel mode.
- Configuration is loaded through a valid/ready port while idle. Runs are started and stopped by pulses, for a finite or infinite number of frames.
- Standalone leaf block; outputs are fully registered.

Parameters:
- N_CH, 4, number of output channels (>=1).
- CNT_W, 16, frame counter and window bound width.
- FRAME_LEN, 1000, cycles per frame (2..2**CNT_W).
- CH_W, $clog2(N_CH) (min 1), channel index width; localparam, not overridable.

Ports:
- clk, in, 1, sole clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse; begins a run from IDLE.
- stop, in, 1, pulse; aborts a run to IDLE.
- num_frames, in, 8, frames per run, sampled on accepted start; 0 = run forever.
- cfg_valid, in, 1, config write request.
- cfg_ready, out, 1, config write accepted when high together with cfg_valid.
- cfg_ch, in, CH_W, channel index to write.
- cfg_lo, in, CNT_W, window start (inclusive).
- cfg_hi, in, CNT_W, window end (inclusive).
- cfg_mode, in, 2, 0=OFF, 1=LEVEL, 2=STROBE, 3=INVERT.
- wave, out, N_CH, per-channel waveform.
- frame_cnt, out, CNT_W, current frame position.
- frame_done, out, 1, high when frame_cnt==FRAME_LEN-1 in RUN.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse when a finite run completes.

Behaviour:
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN on start && !stop. This loads frames_left=num_frames, frame_cnt=0 and phase=0.
  - RUN->IDLE on stop. No done pulse is produced.
  - RUN->DONE when frame_cnt==FRAME_LEN-1, num_frames!=0 and frames_left==1.
  - DONE->IDLE unconditionally after 1 cycle; done=1 only in DONE.
  - start while RUN or DONE is ignored. stop wins over start in the same cycle.
- Reset values: state=IDLE; frame_cnt=0; wave=0; frame_done=0; busy=0; done=0; cfg_ready=1.
  - All channel config registers reset to lo=0, hi=0, mode=OFF.
- Frame counter:
  - Increments by 1 each RUN cycle and wraps FRAME_LEN-1 -> 0.
  - On wrap, frames_left decrements when num_frames!=0.
  - Holds at 0 in IDLE and DONE.
- Window test: active_i = (lo_i <= cnt) && (cnt <= hi_i), unsigned compare at CNT_W.
  - If lo_i > hi_i the window is empty and the channel is never active.
  - Bounds >= FRAME_LEN simply never match.
- Output timing:
  - wave is registered and computed from the next-state count, so wave[i] is cycle-aligned with the frame_cnt output.
  - wave = 0 in IDLE and DONE, including INVERT channels.
- Modes (RUN only):
  - OFF: 0.
  - LEVEL: active_i.
  - STROBE: active_i & ~phase. phase toggles every RUN cycle and is cleared at run start, so the pattern is 1,0,1,... aligned to even frame_cnt.
  - INVERT: ~active_i.
- Config port:
  - cfg_ready = (state==IDLE).
  - A write is accepted when cfg_valid && cfg_ready, and updates channel cfg_ch on the next edge.
  - cfg_ch >= N_CH is accepted and dropped.
  - A write in the same cycle as an accepted start lands before the first RUN cycle is evaluated.
- Reset mid-run: the asynchronous reset returns everything to reset values immediately, including config.

Optional Feature:
- Macro: WAVE_WINDOW_MIRROR_EN. Gives two-sided symmetric patterns.
- Defined:
  - The active test also matches a mirrored window [FRAME_LEN-1-hi_i, FRAME_LEN-1-lo_i].
  - Mirroring applies only when hi_i <= FRAME_LEN-1 and lo_i <= hi_i.
  - The final active_i is the OR of the primary and mirrored tests.
- Undefined: primary window only; no extra logic.

Decomposition:
- Package wave_window_pkg holds:
  - the wave_mode_e enum (OFF, LEVEL, STROBE, INVERT);
  - the wave_state_e enum (IDLE, RUN, DONE);
  - the ch_cfg_t struct {lo, hi, mode} parametrised through CNT_W, typedef'd with a package default width of 16.
- One sub-module, wave_window_ch: per-channel config register, window compare (plus mirror) and mode shaping. The top instantiates it N_CH times via generate.

Test Plan:
- FRAME_LEN=20. ch0 LEVEL [5,8], num_frames=1, start -> wave[0]=1 exactly when frame_cnt is 5..8. frame_done at frame_cnt=19. done pulse 1 cycle later. busy drops and cfg_ready rises.
- ch1 STROBE [4,9], ch2 INVERT [4,9], num_frames=2 -> wave[1]=1 at frame_cnt 4,6,8. wave[2]=0 on 4..9, 1 elsewhere. Pattern repeats in frame 2, then done. wave=0 in IDLE.
- num_frames=0, stop at frame_cnt=7 of frame 3 -> next cycle IDLE, frame_cnt=0, wave=0, no done. start+stop in the same cycle from IDLE -> stays IDLE.
- cfg_valid during RUN -> cfg_ready=0, no change. cfg_ch=N_CH -> dropped. lo=9, hi=4 -> channel never active.
- reset_n asserted at frame_cnt=12 -> immediate wave=0, frame_cnt=0, config back to OFF. No output activity after release until the next start.
- With WAVE_WINDOW_MIRROR_EN, FRAME_LEN=100, ch0 LEVEL [20,29] -> active on 20..29 and 70..79.
